imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image over a byte stream and writes it, one 32-bit
// word at a time, into an instruction memory. It holds the core in reset until the image has
// loaded.
//
// Frame: 0xA5 magic, 16-bit word count N (LSB first), N little-endian 32-bit words, and then an
// optional checksum byte (the XOR of the 4N payload bytes).
//
// Build option:
//   IMEM_LOADER_CSUM_EN  defined   -> the checksum byte is expected and checked in the CSUM state
//                        undefined -> there is no checksum byte; the last word goes straight to DONE
//
// Ports:
//   clk, rst_n     system clock; asynchronous active-low reset
//   rx_valid/data  upstream byte stream
//   rx_ready       byte accepted when rx_valid && rx_ready at a rising edge
//   imem_we        one-cycle write strobe; imem_addr is a word-aligned byte address; imem_wdata
//                  is the word to write
//   core_rst_n     active-low core reset; released only when the load completes
//   busy           a frame is in progress
//   done           sticky flag: the load succeeded
//   err            sticky flag: the frame was rejected
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    localparam logic [7:0] Magic = 8'hA5;

`ifdef IMEM_LOADER_CSUM_EN
    localparam state_e StAfterData = StCsum;
`else
    localparam state_e StAfterData = StDone;
`endif

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;        // word count N
    logic [15:0] widx_q, widx_d;      // index of the word being assembled
    logic [1:0]  bcnt_q, bcnt_d;      // byte position within the current word
    logic [23:0] asm_q, asm_d;        // bytes 0..2 of the current word
    logic [7:0]  len0_q, len0_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        core_rst_n_q, core_rst_n_d;

    logic        accept;
    logic [15:0] word_count;

    assign accept     = rx_valid && ready_q;
    assign word_count = {rx_data, len0_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        len0_d  = len0_q;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d  = csum_q;
`endif
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (accept) begin
            case (state_q)
                StIdle: begin
                    if (rx_data == Magic) begin
                        state_d = StLen0;
                        widx_d  = 16'd0;
                        bcnt_d  = 2'd0;
                        asm_d   = 24'd0;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_d  = 8'd0;
`endif
                    end
                end
                StLen0: begin
                    len0_d  = rx_data;
                    state_d = StLen1;
                end
                StLen1: begin
                    cnt_d = word_count;
                    if (32'(word_count) > MAX_WORDS) begin
                        state_d = StErr;
                    end else if (word_count == 16'd0) begin
                        state_d = StAfterData;
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            // The fourth byte completes the word; the strobe goes out next cycle.
                            we_d    = 1'b1;
                            addr_d  = BASE_ADDR + {14'd0, widx_q, 2'b00};
                            wdata_d = {rx_data, asm_q};
                            widx_d  = widx_q + 16'd1;
                            if (widx_q == cnt_q - 16'd1) begin
                                state_d = StAfterData;
                            end
                        end
                    endcase
                end
`ifdef IMEM_LOADER_CSUM_EN
                StCsum: begin
                    state_d = (rx_data == csum_q) ? StDone : StErr;
                end
`endif
                default: ;
            endcase
        end

        // Status outputs are registered from the next state, so they line up with state_q.
        ready_d      = (state_d != StDone) && (state_d != StErr);
        busy_d       = (state_d != StIdle) && (state_d != StDone) && (state_d != StErr);
        done_d       = (state_d == StDone);
        err_d        = (state_d == StErr);
        core_rst_n_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 16'd0;
            widx_q       <= 16'd0;
            bcnt_q       <= 2'd0;
            asm_q        <= 24'd0;
            len0_q       <= 8'd0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q       <= 8'd0;
`endif
            we_q         <= 1'b0;
            addr_q       <= BASE_ADDR;
            wdata_q      <= 32'd0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            widx_q       <= widx_d;
            bcnt_q       <= bcnt_d;
            asm_q        <= asm_d;
            len0_q       <= len0_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q       <= csum_d;
`endif
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign rx_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
